ocp_initiator: RTL and testbench

OCP_INITIATOR -- requirements
Module: ocp_initiator

---
 rtl/ocp_initiator.sv | 197 +++++++++++++++++++
 tb/tb_ocp_initiator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ocp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : ocp_initiator
//  Brief    : Single-outstanding OCP master. Accepts one client request,
//             issues it on the OCP request phase, waits for the slave
//             response (or a cycle-count timeout) and returns a status.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ  3'b010
`endif

module ocp_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_wr,
  input  logic [`ADDR_WIDTH-1:0] i_req_addr,
  input  logic [`DATA_WIDTH-1:0] i_req_data,
  input  logic [`BEN_WIDTH-1:0]  i_req_ben,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [`DATA_WIDTH-1:0] o_rsp_data,
  output logic [1:0]             o_rsp_status,
  output logic [`ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]             o_MCmd,
  output logic [`DATA_WIDTH-1:0] o_MData,
  output logic [`BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                   i_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]             i_SResp
);

  // OCP response codes
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_FAIL = 2'b10;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  // Client status codes
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  // Counter value at which the transaction is abandoned
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [15:0]              cnt;
  logic                     cnt_inc;
  logic                     capture;
  logic                     timeout;
  logic                     req_hs;
  logic                     at_limit;
  logic                     resp_seen;
  logic                     wr_q;
  logic [`ADDR_WIDTH-1:0]   addr_q;
  logic [`DATA_WIDTH-1:0]   data_q;
  logic [`BEN_WIDTH-1:0]    ben_q;
  logic [1:0]               cap_status;
  logic [`DATA_WIDTH-1:0]   cap_data;

  assign req_hs    = i_req_valid && (state == IDLE);
  assign at_limit  = (cnt == LIMIT);
  assign resp_seen = (i_SResp != RESP_NULL);

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and OCP/client output generation
  always_comb begin
    state_nxt   = state;
    cnt_inc     = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_MCmd      = `OCP_CMD_IDLE;
    o_MAddr     = '0;
    o_MData     = '0;
    o_MByteEn   = '0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = CMD;
      end
      CMD: begin
        cnt_inc   = 1'b1;
        o_MCmd    = wr_q ? `OCP_CMD_WRITE : `OCP_CMD_READ;
        o_MAddr   = addr_q;
        o_MData   = data_q;
        o_MByteEn = ben_q;
        // A zero-latency reply wins over a timeout on the same edge
        if (i_SCmdAccept && resp_seen) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (at_limit) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end else if (i_SCmdAccept) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        cnt_inc = 1'b1;
        if (resp_seen) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (at_limit) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Translate the slave reply into client status and read data
  always_comb begin
    cap_status = ST_OK;
    cap_data   = '0;
    case (i_SResp)
      RESP_DVA:  cap_status = ST_OK;
      RESP_ERR:  cap_status = ST_ERR;
      RESP_FAIL: cap_status = ST_FAIL;
      default:   cap_status = ST_OK;
    endcase
    if (!wr_q && (i_SResp == RESP_DVA)) cap_data = i_SData;
  end

  // Request latch, saturating cycle counter and response capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ben_q        <= '0;
      cnt          <= '0;
      o_rsp_data   <= '0;
      o_rsp_status <= ST_OK;
    end else begin
      if (req_hs) begin
        wr_q   <= i_req_wr;
        addr_q <= i_req_addr;
        data_q <= i_req_data;
        ben_q  <= i_req_ben;
        cnt    <= '0;
      end else if (cnt_inc && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
      if (capture) begin
        o_rsp_data   <= cap_data;
        o_rsp_status <= cap_status;
      end else if (timeout) begin
        o_rsp_data   <= '0;
        o_rsp_status <= ST_TMO;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ocp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ocp_initiator
//  Brief    : Self-checking bench for ocp_initiator: directed scenarios plus
//             randomized transactions against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

module tb_ocp_initiator;

  localparam int TMO = 8;
  localparam logic [1:0] NUL = 2'b00, DVA = 2'b01, FAI = 2'b10, ERR = 2'b11;

  logic                   clk = 1'b0;
  logic                   nrst;
  logic                   i_req_valid, o_req_ready, i_req_wr;
  logic [`ADDR_WIDTH-1:0] i_req_addr, o_MAddr;
  logic [`DATA_WIDTH-1:0] i_req_data, o_rsp_data, o_MData, i_SData;
  logic [`BEN_WIDTH-1:0]  i_req_ben, o_MByteEn;
  logic                   o_rsp_valid, i_rsp_ready, i_SCmdAccept;
  logic [1:0]             o_rsp_status, i_SResp;
  logic [2:0]             o_MCmd;

  int compared   = 0;
  int mismatched = 0;

  ocp_initiator #(.TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_ben(i_req_ben),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status),
    .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
    .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
  );

  always #5 clk = ~clk;

  // Hard stop in case something blocks forever
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: cycles are numbered from the first command cycle.
  // The slave accepts on cycle a and replies on cycle a+r; the initiator gives
  // up on cycle TMO-1 unless a reply arrives on or before that cycle.
  task automatic predict(input int a, input int r, input logic [1:0] code,
                         input logic wr, input logic [31:0] sdata,
                         output int cmd_cycles, output int end_cycle,
                         output logic [1:0] st, output logic [31:0] d);
    logic [1:0] map [4];
    map[0] = 2'b00; map[1] = 2'b00; map[2] = 2'b10; map[3] = 2'b01;
    cmd_cycles = (a <= TMO - 1) ? a + 1 : TMO;
    if (code != NUL && (a + r) <= TMO - 1) begin
      end_cycle = a + r;
      st        = map[code];
      d         = (!wr && code == DVA) ? sdata : 32'h0;
    end else begin
      end_cycle = TMO - 1;
      st        = 2'b11;
      d         = 32'h0;
    end
  endtask

  // Runs one transaction starting from a falling edge with the DUT idle
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] ben,
                         input int a, input int r, input logic [1:0] code,
                         input logic [31:0] sdata, input int hold);
    int cmd_exp, end_exp, cmd_seen, bad, k;
    logic [1:0] st;
    logic [31:0] d;
    logic [2:0] ecmd;
    predict(a, r, code, wr, sdata, cmd_exp, end_exp, st, d);
    ecmd = wr ? 3'b001 : 3'b010;
    check({tag, "/req_ready"}, 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1; i_req_wr = wr; i_req_addr = addr;
    i_req_data = data; i_req_ben = ben;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_data = $urandom;
    i_req_ben = 4'($urandom); i_req_wr = 1'($urandom);
    cmd_seen = 0; bad = 0; k = 0;
    while (k < 64) begin
      @(negedge clk);
      if (o_rsp_valid) break;
      if (o_MCmd != 3'b000) cmd_seen++;
      if (k < cmd_exp) begin
        if ({o_MCmd, o_MAddr, o_MData, o_MByteEn} !== {ecmd, addr, data, ben}) bad++;
      end else if ({o_MCmd, o_MAddr, o_MData, o_MByteEn} !== '0) bad++;
      i_SCmdAccept = (k == a);
      i_SResp      = (k == a + r) ? code : NUL;
      i_SData      = (k == a + r) ? sdata : $urandom;
      k++;
    end
    check({tag, "/rsp_valid"}, 64'(o_rsp_valid), 64'd1);
    check({tag, "/latency"}, 64'(k), 64'(end_exp + 1));
    check({tag, "/cmd_cycles"}, 64'(cmd_seen), 64'(cmd_exp));
    check({tag, "/req_phase"}, 64'(bad), 64'd0);
    // Response must stay put while the client stalls; slave noise is ignored
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check({tag, "/done"},
            64'({o_rsp_valid, o_req_ready, o_MCmd, o_rsp_status, o_rsp_data}),
            64'({1'b1, 1'b0, 3'b000, st, d}));
      i_SCmdAccept = 1'($urandom);
      i_SResp      = DVA;
      i_SData      = $urandom;
      i_rsp_ready  = (h == hold);
    end
    @(negedge clk);
    i_rsp_ready = 1'b0; i_SResp = NUL; i_SCmdAccept = 1'b0;
    check({tag, "/back_idle"}, 64'({o_req_ready, o_rsp_valid}), 64'(2'b10));
  endtask

  initial begin
    nrst = 1'b0; i_req_valid = 0; i_req_wr = 0; i_req_addr = 0; i_req_data = 0;
    i_req_ben = 0; i_rsp_ready = 0; i_SCmdAccept = 0; i_SData = 0; i_SResp = NUL;

    #12;
    check("reset/outputs",
          64'({o_MCmd, o_rsp_valid, o_rsp_status, o_rsp_data, o_req_ready}),
          64'({3'b000, 1'b0, 2'b00, 32'h0, 1'b1}));
    check("reset/req_bus", 64'({o_MAddr, o_MByteEn}), 64'd0);
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    #1 check("release/req_ready", 64'(o_req_ready), 64'd1);
    @(negedge clk);

    // Directed scenarios
    run_txn("wr_zero_lat", 1'b1, 32'h100, 32'h5A, 4'hF, 0, 0, DVA, 32'hDEAD_BEEF, 0);
    run_txn("rd_wait3", 1'b0, 32'h000, 32'h0, 4'hF, 3, 0, DVA, 32'h0001_0000, 1);
    run_txn("err_after_resp", 1'b0, 32'h44, 32'h0, 4'h3, 0, 2, ERR, 32'h1234, 0);
    run_txn("timeout", 1'b0, 32'h80, 32'h0, 4'hF, 100, 0, DVA, 32'h5555, 3);
    run_txn("stall5", 1'b0, 32'hC0, 32'h0, 4'h1, 1, 0, DVA, 32'hCAFE_F00D, 5);
    run_txn("fail_rd", 1'b0, 32'h10, 32'h0, 4'hF, 2, 1, FAI, 32'h7777, 0);
    run_txn("prio_edge", 1'b0, 32'h20, 32'h0, 4'hF, 7, 0, DVA, 32'hA5A5_0001, 0);
    run_txn("late_after_acc", 1'b1, 32'h24, 32'h9, 4'hF, 7, 1, DVA, 32'h1, 0);
    run_txn("edge_resp", 1'b0, 32'h28, 32'h0, 4'hF, 6, 1, DVA, 32'hBEEF_0002, 0);

    // Reset asserted while waiting in RESP
    i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 32'h300; i_req_ben = 4'hF;
    @(posedge clk); #1 i_req_valid = 1'b0;
    @(negedge clk); i_SCmdAccept = 1'b1; i_SResp = NUL;
    @(negedge clk); i_SCmdAccept = 1'b0;
    check("rst_mid/in_resp", 64'({o_MCmd, o_rsp_valid}), 64'd0);
    #2 nrst = 1'b0;
    #1 check("rst_mid/immediate",
             64'({o_MCmd, o_rsp_valid, o_rsp_status, o_rsp_data, o_MAddr}), 64'd0);
    i_SResp = DVA; i_SData = 32'hBAD0_BAD0;
    @(negedge clk); nrst = 1'b1;
    #1 check("rst_mid/ready", 64'(o_req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid/no_stale", 64'({o_rsp_valid, o_req_ready, o_MCmd}), 64'(5'b01000));
    end
    i_SResp = NUL;

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      logic [1:0] code;
      code = ($urandom_range(0, 7) == 0) ? NUL : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        i_SResp = DVA; i_SData = $urandom;
        @(negedge clk);
        i_SResp = NUL;
      end
      run_txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 10), $urandom_range(0, 4), code, $urandom,
              $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
